// File: rtl/fft_corr_pkg.sv
// Shared constants and types for the F1 correlation front end.
package fft_corr_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8192;
    localparam int unsigned LEN_W  = 14;

    // Sample count shared with the receive stage's N1 port (0..DEPTH).
    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REPLAY = 2'd2
    } buf_state_e;

endpackage

// File: rtl/sp_ram_sync.sv
// Simple dual-port RAM: one write port, one synchronous read port, 1-cycle read latency.
module sp_ram_sync #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 8192
) (
    input  logic              aclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read; contents are never reset so this maps onto block RAM.
    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/f1_sample_buffer.sv
// Stores F1 once from a load stream and replays it as an AXI-Stream burst on each start.
module f1_sample_buffer #(
    parameter int unsigned DEPTH  = fft_corr_pkg::DEPTH,
    parameter int unsigned DATA_W = fft_corr_pkg::DATA_W
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           load_start,
    input  logic [DATA_W-1:0]              s_tdata,
    input  logic                           s_tvalid,
    input  logic                           s_tlast,
    output logic                           s_tready,
    input  logic                           start,
    output logic [DATA_W-1:0]              m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [fft_corr_pkg::LEN_W-1:0] n_stored,
    output logic                           load_done,
    output logic                           replay_done,
    output logic                           busy
);

    import fft_corr_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    buf_state_e        state;
    len_t              wr_cnt;
    len_t              rd_cnt;
    len_t              out_cnt;
    logic              wr_en;
    logic              wr_last;
    logic              rd_en;
    logic              start_ok;
    logic              pop;
    logic [1:0]        slots_used;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_pending;
    logic              spare_valid;
    logic [DATA_W-1:0] spare_data;
    logic              out_load;
    logic              spare_load;

    assign pop      = m_tvalid & m_tready;
    assign wr_en    = (state == ST_LOAD) & s_tvalid & s_tready;
    assign wr_last  = wr_en & (s_tlast | (wr_cnt == len_t'(DEPTH - 1)));
    assign start_ok = (state == ST_IDLE) & start & ~load_start & (n_stored != '0);

    // Slots still claimed after this cycle's pop: skid entries plus the read in flight.
    assign slots_used = 2'(m_tvalid) + 2'(spare_valid) + 2'(rd_pending) - 2'(pop);

    // Word 0 is fetched while still in IDLE so the first beat appears two cycles after start.
    assign rd_en   = start_ok |
                     ((state == ST_REPLAY) & (rd_cnt < n_stored) & (slots_used < 2'd2));
    assign rd_addr = start_ok ? '0 : ADDR_W'(rd_cnt);

    assign replay_done = (state == ST_REPLAY) & pop & (out_cnt == (n_stored - len_t'(1)));

    sp_ram_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .aclk  (aclk),
        .we    (wr_en),
        .waddr (ADDR_W'(wr_cnt)),
        .wdata (s_tdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Control FSM: load/replay sequencing, counters and the published length.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            s_tready  <= 1'b0;
            load_done <= 1'b0;
            n_stored  <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b1;
                        s_tready <= 1'b1;
                        n_stored <= '0;
                        wr_cnt   <= '0;
                    end else if (start_ok) begin
                        state   <= ST_REPLAY;
                        busy    <= 1'b1;
                        rd_cnt  <= len_t'(1);
                        out_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + len_t'(1);
                        if (wr_last) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            s_tready  <= 1'b0;
                            n_stored  <= wr_cnt + len_t'(1);
                            load_done <= 1'b1;
                        end
                    end
                end
                ST_REPLAY: begin
                    if (rd_en) begin
                        rd_cnt <= rd_cnt + len_t'(1);
                    end
                    if (pop) begin
                        out_cnt <= out_cnt + len_t'(1);
                    end
                    if (replay_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    s_tready <= 1'b0;
                end
            endcase
        end
    end

    // Output slot refills when empty or draining; the spare slot catches a read landing during a stall.
    assign out_load   = pop | ~m_tvalid;
    assign spare_load = (spare_valid & out_load) | (~spare_valid & ~out_load & rd_pending);

    // Skid occupancy; flushed on reset and once the last beat has been accepted.
    always_ff @(posedge aclk) begin
        if (areset || replay_done) begin
            m_tvalid    <= 1'b0;
            spare_valid <= 1'b0;
            rd_pending  <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            if (out_load) begin
                m_tvalid    <= spare_valid | rd_pending;
                spare_valid <= spare_valid & rd_pending;
            end else if (rd_pending) begin
                spare_valid <= 1'b1;
            end
        end
    end

    // Skid data path; oldest word always goes to the output slot first.
    always_ff @(posedge aclk) begin
        if (out_load) begin
            m_tdata <= spare_valid ? spare_data : rd_data;
        end
        if (spare_load) begin
            spare_data <= rd_data;
        end
    end

endmodule
